// File: rtl/tx_burst_gen_pkg.sv
// tx_burst_gen_pkg: probe modes, FSM encoding and drive polarity shared by the transmit and receive-switch stages.
package tx_burst_gen_pkg;
   localparam logic [7:0] MODE_TXRX  = 8'd1;
   localparam logic [7:0] MODE_TX    = 8'd2;
   localparam logic [7:0] MODE_RX    = 8'd3;
   localparam logic [7:0] MODE_CLOSE = 8'd4;
   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;
   typedef enum logic [1:0] {IDLE, SHOT, BURST, WAIT} state_t;
   function automatic logic mode_active(input logic [7:0] m);
      return m == MODE_TXRX || m == MODE_TX || m == MODE_RX;
   endfunction
endpackage

// File: rtl/tx_carrier_gen.sv
// tx_carrier_gen: half-phase and carrier-cycle counters producing TX_P/TX_N for one burst.
// TX_DEADTIME_EN inserts one idle clock after every half-phase.
module tx_carrier_gen
   import tx_burst_gen_pkg::*;
#(
   parameter int HALF_CYC = 2
) (
   input  logic       CLOCK_10M,
   input  logic       RST_N,
   input  logic       start,
   input  logic       stop,
   input  logic [7:0] BURST_LEN,
   output logic       done,
   output logic       TX_P,
   output logic       TX_N
);
`ifdef TX_DEADTIME_EN
   localparam int DEAD = 1;
`else
   localparam int DEAD = 0;
`endif
   localparam logic [7:0] PH_MAX  = 8'(HALF_CYC - 1 + DEAD);
   localparam logic [7:0] PH_DEAD = 8'(HALF_CYC);
   logic       active, neg, ph_wrap, nx_active, nx_neg, nx_dead;
   logic [7:0] ph, cyc, len_l, nx_ph, nx_cyc;
   always_comb begin
      ph_wrap   = ph == PH_MAX;
      done      = active & neg & ph_wrap & (cyc == len_l - 8'd1);
      nx_active = ~stop & (start | (active & ~done));
      nx_ph     = (start | ph_wrap) ? 8'd0 : ph + 8'd1;
      nx_neg    = ~start & (neg ^ ph_wrap);
      nx_cyc    = start ? 8'd0 : cyc + {7'd0, ph_wrap & neg};
      nx_dead   = (DEAD != 0) && (nx_ph == PH_DEAD);
   end
   // Outputs are registered from the next-cycle counter values so they line up with MA.
   always_ff @(posedge CLOCK_10M or negedge RST_N) begin
      if (!RST_N) begin
         active <= 1'b0;
         neg    <= 1'b0;
         ph     <= '0;
         cyc    <= '0;
         len_l  <= '0;
         TX_P   <= OFF;
         TX_N   <= OFF;
      end else begin
         active <= nx_active;
         neg    <= nx_neg;
         ph     <= nx_ph;
         cyc    <= nx_cyc;
         if (start) len_l <= BURST_LEN;
         TX_P   <= (nx_active & ~nx_neg & ~nx_dead) ? ON : OFF;
         TX_N   <= (nx_active & nx_neg & ~nx_dead) ? ON : OFF;
      end
   end
endmodule

// File: rtl/tx_burst_gen.sv
// tx_burst_gen: shot FSM and period counter generating GEN, MA and the bipolar carrier burst.
// Optional macro TX_DEADTIME_EN adds a dead clock after each carrier half-phase.
module tx_burst_gen
   import tx_burst_gen_pkg::*;
#(
   parameter int HALF_CYC = 2,
   parameter int PERIOD_W = 16
) (
   input  logic                CLOCK_10M,
   input  logic                RST_N,
   input  logic                SW_EN,
   input  logic [7:0]          PROBE_MODE,
   input  logic [PERIOD_W-1:0] PERIOD,
   input  logic [7:0]          BURST_LEN,
   output logic                GEN,
   output logic                MA,
   output logic                TX_P,
   output logic                TX_N
);
   state_t              state, nx, after;
   logic [PERIOD_W-1:0] cnt, per_l, per_e, per_m1;
   logic                sh, live_ok, burst_go, period_end, start, done;
   // In SHOT the shadow registers are being loaded, so decisions use the live inputs.
   always_comb begin
      sh         = state == SHOT;
      per_e      = sh ? PERIOD : per_l;
      per_m1     = (per_e == '0) ? '0 : per_e - PERIOD_W'(1);
      period_end = cnt >= per_m1;
      live_ok    = mode_active(PROBE_MODE);
      burst_go   = (PROBE_MODE == MODE_TXRX || PROBE_MODE == MODE_TX) && BURST_LEN != 8'd0;
      after      = period_end ? (live_ok ? SHOT : IDLE) : WAIT;
      nx         = IDLE;
      case (state)
         IDLE:  nx = live_ok ? SHOT : IDLE;
         SHOT:  nx = burst_go ? BURST : after;
         BURST: nx = done ? after : BURST;
         WAIT:  nx = after;
      endcase
      if (!SW_EN) nx = IDLE;
      start = sh && nx == BURST;
   end
   always_ff @(posedge CLOCK_10M or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         cnt   <= '0;
         per_l <= '0;
         GEN   <= OFF;
         MA    <= OFF;
      end else begin
         state <= nx;
         cnt   <= (nx == SHOT) ? '0 : (&cnt ? cnt : cnt + PERIOD_W'(1));
         if (sh) per_l <= PERIOD;
         GEN   <= (nx == SHOT) ? ON : OFF;
         MA    <= (nx == BURST) ? ON : OFF;
      end
   end
   tx_carrier_gen #(.HALF_CYC(HALF_CYC)) u_carrier (
      .CLOCK_10M(CLOCK_10M),
      .RST_N    (RST_N),
      .start    (start),
      .stop     (~SW_EN),
      .BURST_LEN(BURST_LEN),
      .done     (done),
      .TX_P     (TX_P),
      .TX_N     (TX_N)
   );
endmodule

// File: tb/tb_tx_burst_gen.sv
// tb_tx_burst_gen: directed and random shots checked against a time-since-GEN reference model.
module tb_tx_burst_gen;
   localparam int HALF_CYC = 2;
`ifdef TX_DEADTIME_EN
   localparam int LC = HALF_CYC + 1;
`else
   localparam int LC = HALF_CYC;
`endif
   logic        CLOCK_10M = 1'b0;
   logic        RST_N = 1'b0;
   logic        SW_EN = 1'b0;
   logic [7:0]  PROBE_MODE = '0;
   logic [7:0]  BURST_LEN = '0;
   logic [15:0] PERIOD = '0;
   logic        GEN, MA, TX_P, TX_N;
   int          checks = 0;
   int          errors = 0;
   bit          run = 0;
   int          t = 0;
   int          mp = 1;
   int          mb = 0;
   logic [7:0]  modes [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd0, 8'd1, 8'd2};

   always #50 CLOCK_10M = ~CLOCK_10M;

   tx_burst_gen #(.HALF_CYC(HALF_CYC), .PERIOD_W(16)) dut (
      .CLOCK_10M (CLOCK_10M),
      .RST_N     (RST_N),
      .SW_EN     (SW_EN),
      .PROBE_MODE(PROBE_MODE),
      .PERIOD    (PERIOD),
      .BURST_LEN (BURST_LEN),
      .GEN       (GEN),
      .MA        (MA),
      .TX_P      (TX_P),
      .TX_N      (TX_N)
   );

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: {GEN,MA,TX_P,TX_N} got %b expected %b", tag, $time, got, exp);
      end
   endtask

   function automatic bit ok(input logic [7:0] m);
      return m >= 8'd1 && m <= 8'd3;
   endfunction

   // t counts clocks since the last GEN; the next GEN is due at max(period, burst+1).
   task automatic model_step();
      if (!RST_N || !SW_EN) run = 0;
      else if (!run) begin
         if (ok(PROBE_MODE)) begin
            run = 1;
            t = 0;
         end
      end else begin
         if (t == 0) begin
            mp = (PERIOD == 0) ? 1 : int'(PERIOD);
            mb = (PROBE_MODE == 8'd1 || PROBE_MODE == 8'd2) ? int'(BURST_LEN) * 2 * LC : 0;
         end
         if (t == ((mp > mb + 1) ? mp : mb + 1) - 1) begin
            if (ok(PROBE_MODE)) t = 0;
            else run = 0;
         end else t++;
      end
   endtask

   function automatic logic [3:0] model_out();
      int pos;
      logic ma;
      if (!run) return 4'b0000;
      ma = t >= 1 && t <= mb;
      pos = (t - 1) % (2 * LC);
      return {t == 0, ma, ma && pos < HALF_CYC, ma && pos >= LC && pos < LC + HALF_CYC};
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLOCK_10M);
         model_step();
         @(negedge CLOCK_10M);
         check("out", {GEN, MA, TX_P, TX_N}, model_out());
      end
   endtask

   task automatic set(input logic sw, input logic [7:0] m, input int p, input int l);
      SW_EN = sw;
      PROBE_MODE = m;
      PERIOD = 16'(p);
      BURST_LEN = 8'(l);
   endtask

   initial begin
      step(3);
      RST_N = 1'b1;
      set(1, 1, 100, 3);
      step(210);
      set(1, 1, 5, 3);
      step(60);
      set(1, 3, 50, 0);
      step(120);
      set(1, 7, 50, 0);
      step(80);
      set(1, 1, 100, 3);
      step(7);
      SW_EN = 1'b0;
      step(5);
      SW_EN = 1'b1;
      step(30);
      SW_EN = 1'b0;
      step(2);
      SW_EN = 1'b1;
      step(5);
      #10 RST_N = 1'b0;
      #1 check("async_rst", {GEN, MA, TX_P, TX_N}, 4'b0000);
      run = 0;
      step(2);
      RST_N = 1'b1;
      step(40);
      set(1, 2, 40, 2);
      step(4);
      BURST_LEN = 8'd5;
      step(90);
      set(1, 1, 0, 0);
      step(10);
      set(1, 1, 1, 1);
      step(20);
      set(1, 4, 20, 2);
      step(30);
      for (int i = 0; i < 40; i++) begin
         set($urandom_range(0, 9) != 0, modes[$urandom_range(0, 7)],
             $urandom_range(0, 40), $urandom_range(0, 5));
         step($urandom_range(5, 60));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
